btn_event_dec: RTL and testbench
================================

Name: btn_event_dec

Overview:
Consumer of the debounced button level produced by the debounce stage. It classifies button activity into three one-cycle event pulses: short press, long press, and double click. Downstream FPGA logic such as mode FSMs and counters uses these pulses instead of raw level edges. Input is synchronous to clk and already debounced; no metastability or bounce filtering happens here.

Parameters:
T_LONG, 26'd50_000_000, hold time in cycles for a long press (1 s at 50 MHz); minimum 2.
T_DBL, 26'd12_500_000, window in cycles after first release for a second press (250 ms); minimum 2.
T_RPT, 26'd10_000_000, auto-repeat period in cycles; used only with BTN_REPEAT_EN.
CNT_W, 26, counter width; every T_* must be below 2**CNT_W.

Ports:
clk      input   1  system clock, rising edge.
n_rst    input   1  reset, asynchronous, active-low.
din      input   1  debounced button level, 1 = pressed.
pressed  output  1  registered copy of din.
short_p  output  1  single-click event, 1-cycle pulse.
long_p   output  1  long-press event, 1-cycle pulse.
dbl_p    output  1  double-click event, 1-cycle pulse.

Behaviour:
- Reset (async assert, sync release): state=IDLE, cnt=0, din_d=1, pressed=0, short_p=long_p=dbl_p=0.
- din_d resets to 1 so that a button held through reset produces no rise. The button must be released and pressed again before any event fires.
- Edge detect: rise = din & ~din_d; fall = ~din & din_d. din_d <= din every cycle. pressed <= din.
- All event outputs are registered. Each is high for exactly one cycle. At most one event output is high in any cycle.
- Counter: cnt clears on every state change and increments by 1 each cycle while in PRESS1 or WAIT2. It never wraps, because each terminal compare forces a state exit.
- FSM states: IDLE, PRESS1, WAIT2, PRESS2, HOLD.
  - IDLE: rise -> PRESS1. A fall is ignored.
  - PRESS1: fall -> WAIT2. Otherwise, when cnt==T_LONG-1 with din=1 -> long_p=1 next cycle, go to HOLD.
  - WAIT2: rise -> PRESS2, with dbl_p=1 next cycle. Otherwise, when cnt==T_DBL-1 with din=0 -> short_p=1 next cycle, go to IDLE.
  - PRESS2: waits for release; no long detection. fall -> IDLE.
  - HOLD: fall -> IDLE.
- Latencies:
  - long_p asserts T_LONG cycles after the edge that entered PRESS1.
  - short_p asserts T_DBL cycles after the edge that entered WAIT2.
  - dbl_p asserts 1 cycle after the edge that detects the second rise.
- Simultaneous events:
  - Rise on the same cycle as the WAIT2 terminal count: rise wins, giving dbl_p and no short_p.
  - Fall on the same cycle as the PRESS1 terminal count: fall wins, giving WAIT2 and no long_p.
- Reset mid-operation clears all state immediately. Any pending short_p is discarded.

Optional Feature:
BTN_REPEAT_EN
- Defined: in HOLD, a separate repeat counter runs. long_p pulses again every T_RPT cycles while din=1. The repeat counter clears on entry to HOLD and on each pulse. Fall exits HOLD with no further pulse.
- Undefined: HOLD emits nothing. The repeat counter and the T_RPT logic are absent from the netlist.

Decomposition:
- Shared package/header btn_pkg:
  - State encoding localparams: IDLE=3'd0, PRESS1=3'd1, WAIT2=3'd2, PRESS2=3'd3, HOLD=3'd4.
  - Default timing constants for real hardware and the SIM-define values: T_LONG=16, T_DBL=8, T_RPT=4.
- One sub-module, edge_det: registered din_d with reset value parameter INIT=1, outputs rise/fall. It is reusable for other button inputs.

Test Plan (SIM values T_LONG=16, T_DBL=8, T_RPT=4):
- Press 3 cycles, release, idle 20 cycles -> exactly one short_p, 8 cycles after the release edge; long_p=dbl_p=0.
- Press 3, release 3, press 3, release -> one dbl_p, 1 cycle after the second rise; no short_p; FSM returns to IDLE after the release.
- Hold 30 cycles -> one long_p, 16 cycles after the press edge. Without BTN_REPEAT_EN, no further pulses. With it, additional long_p pulses every 4 cycles until release.
- Release on the cycle cnt==15 in PRESS1 -> no long_p; short_p follows 8 cycles later.
- din held 1 through reset release, then released -> no events. A subsequent 3-cycle press -> short_p.
- Assert n_rst=0 in WAIT2 at cnt=5 -> outputs 0 immediately; no short_p after reset release.

Source files
------------

// File: rtl/btn_pkg.sv
// Shared state encoding and timing constants for btn_event_dec.
// Defining SIM selects the short simulation timings as the module defaults.
package btn_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      PRESS1 = 3'd1,
      WAIT2  = 3'd2,
      PRESS2 = 3'd3,
      HOLD   = 3'd4
   } state_e;

   localparam int unsigned CNT_W_DEF = 26;

   // Real hardware at 50 MHz: 1 s long press, 250 ms double-click window.
   localparam logic [25:0] T_LONG_HW = 26'd50_000_000;
   localparam logic [25:0] T_DBL_HW  = 26'd12_500_000;
   localparam logic [25:0] T_RPT_HW  = 26'd10_000_000;

   localparam logic [25:0] T_LONG_SIM = 26'd16;
   localparam logic [25:0] T_DBL_SIM  = 26'd8;
   localparam logic [25:0] T_RPT_SIM  = 26'd4;

`ifdef SIM
   localparam logic [25:0] T_LONG_DEF = T_LONG_SIM;
   localparam logic [25:0] T_DBL_DEF  = T_DBL_SIM;
   localparam logic [25:0] T_RPT_DEF  = T_RPT_SIM;
`else
   localparam logic [25:0] T_LONG_DEF = T_LONG_HW;
   localparam logic [25:0] T_DBL_DEF  = T_DBL_HW;
   localparam logic [25:0] T_RPT_DEF  = T_RPT_HW;
`endif

endpackage

// File: rtl/btn_event_dec_edge_det.sv
// edge_det: registers a synchronous level and flags its rising and falling edges.
// INIT sets the assumed previous level out of reset.
module edge_det #(
   parameter logic INIT = 1'b1
) (
   input  logic clk,
   input  logic n_rst,
   input  logic din,
   output logic rise,
   output logic fall
);

   logic din_d_q;

   // NOTE: registers take non-blocking assignments so every flop samples the pre-edge values.
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) din_d_q <= INIT;
      else        din_d_q <= din;
   end

   assign rise = din & ~din_d_q;
   assign fall = ~din & din_d_q;

endmodule

// File: rtl/btn_event_dec.sv
// btn_event_dec: turns a debounced button level into short/long/double-click pulses.
// Define BTN_REPEAT_EN to make long_p auto-repeat every T_RPT cycles while held.
module btn_event_dec
   import btn_pkg::*;
#(
   parameter int unsigned      CNT_W  = CNT_W_DEF,
   parameter logic [CNT_W-1:0] T_LONG = CNT_W'(T_LONG_DEF),
   parameter logic [CNT_W-1:0] T_DBL  = CNT_W'(T_DBL_DEF)
`ifdef BTN_REPEAT_EN
   ,parameter logic [CNT_W-1:0] T_RPT = CNT_W'(T_RPT_DEF)
`endif
) (
   input  logic clk,
   input  logic n_rst,
   input  logic din,
   output logic pressed,
   output logic short_p,
   output logic long_p,
   output logic dbl_p
);

   localparam logic [CNT_W-1:0] LONG_TC = T_LONG - CNT_W'(1);
   localparam logic [CNT_W-1:0] DBL_TC  = T_DBL - CNT_W'(1);

   state_e           state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             pressed_q, pressed_d;
   logic             short_p_q, short_p_d;
   logic             long_p_q, long_p_d;
   logic             dbl_p_q, dbl_p_d;
   logic             rise, fall;

   // Previous level resets to 1 so a button held through reset yields no rise.
   edge_det #(.INIT(1'b1)) u_edge (
      .clk   (clk),
      .n_rst (n_rst),
      .din   (din),
      .rise  (rise),
      .fall  (fall)
   );

`ifdef BTN_REPEAT_EN
   localparam logic [CNT_W-1:0] RPT_TC = T_RPT - CNT_W'(1);
   logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
`endif

   always_comb begin
      // NOTE: every combinational output gets a default first, so no path can infer a latch.
      state_d   = state_q;
      cnt_d     = cnt_q;
      pressed_d = din;
      short_p_d = 1'b0;
      long_p_d  = 1'b0;
      dbl_p_d   = 1'b0;

      case (state_q)
         IDLE: begin
            if (rise) state_d = PRESS1;
         end
         PRESS1: begin
            if (fall) begin
               state_d = WAIT2;
            end else if (din && cnt_q == LONG_TC) begin
               long_p_d = 1'b1;
               state_d  = HOLD;
            end
         end
         WAIT2: begin
            if (rise) begin
               dbl_p_d = 1'b1;
               state_d = PRESS2;
            end else if (!din && cnt_q == DBL_TC) begin
               short_p_d = 1'b1;
               state_d   = IDLE;
            end
         end
         PRESS2: begin
            if (fall) state_d = IDLE;
         end
         HOLD: begin
            if (fall) state_d = IDLE;
`ifdef BTN_REPEAT_EN
            else if (din && rpt_cnt_q == RPT_TC) long_p_d = 1'b1;
`endif
         end
         default: state_d = IDLE;
      endcase

      // Each terminal compare leaves the state, so the counter never wraps.
      if (state_d != state_q)
         cnt_d = '0;
      else if (state_q == PRESS1 || state_q == WAIT2)
         cnt_d = cnt_q + CNT_W'(1);
   end

`ifdef BTN_REPEAT_EN
   // Held at zero outside HOLD, so it starts from zero on entry.
   always_comb begin
      if (state_q != HOLD || long_p_d) rpt_cnt_d = '0;
      else                             rpt_cnt_d = rpt_cnt_q + CNT_W'(1);
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) rpt_cnt_q <= '0;
      else        rpt_cnt_q <= rpt_cnt_d;
   end
`endif

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         pressed_q <= 1'b0;
         short_p_q <= 1'b0;
         long_p_q  <= 1'b0;
         dbl_p_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         pressed_q <= pressed_d;
         short_p_q <= short_p_d;
         long_p_q  <= long_p_d;
         dbl_p_q   <= dbl_p_d;
      end
   end

   assign pressed = pressed_q;
   assign short_p = short_p_q;
   assign long_p  = long_p_q;
   assign dbl_p   = dbl_p_q;

endmodule

// File: tb/tb_btn_event_dec.sv
// Directed bench for btn_event_dec using the short simulation timings (16/8/4).
// Build with BTN_REPEAT_EN defined to exercise the auto-repeat variant.
module tb_btn_event_dec;

   localparam int unsigned CNT_W = 26;

`ifdef BTN_REPEAT_EN
   localparam int LONG_HOLD30 = 4;
`else
   localparam int LONG_HOLD30 = 1;
`endif

   // din pattern: 1 for p1 edges, 0 for gap, 1 for p2, 0 for tail.
   // first is the edge index of the first event pulse (-1 = none).
   typedef struct {
      int p1;
      int gap;
      int p2;
      int tail;
      int n_short;
      int n_long;
      int n_dbl;
      int first;
   } scen_t;

   logic clk;
   logic n_rst;
   logic din;
   logic pressed;
   logic short_p;
   logic long_p;
   logic dbl_p;

   int n_checks;
   int n_errors;

   btn_event_dec #(
      .CNT_W  (CNT_W),
      .T_LONG (btn_pkg::T_LONG_SIM),
      .T_DBL  (btn_pkg::T_DBL_SIM)
`ifdef BTN_REPEAT_EN
      ,.T_RPT (btn_pkg::T_RPT_SIM)
`endif
   ) dut (
      .clk     (clk),
      .n_rst   (n_rst),
      .din     (din),
      .pressed (pressed),
      .short_p (short_p),
      .long_p  (long_p),
      .dbl_p   (dbl_p)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input int actual, input int expected);
      n_checks++;
      if (actual != expected) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, actual, expected);
      end
   endtask

   function automatic int out_sum();
      return int'(pressed === 1'b1) + int'(short_p === 1'b1) +
             int'(long_p === 1'b1) + int'(dbl_p === 1'b1);
   endfunction

   // Called #1 after a rising edge; the first driven value is seen by the next edge (index 0).
   task automatic run_scen(input scen_t s, input string tag);
      int n_sh, n_lg, n_db, first, multi, pbad, total;
      logic din_v;
      n_sh = 0; n_lg = 0; n_db = 0; first = -1; multi = 0; pbad = 0;
      total = s.p1 + s.gap + s.p2 + s.tail;
      for (int c = 0; c < total; c++) begin
         din_v = (c < s.p1) || (c >= s.p1 + s.gap && c < s.p1 + s.gap + s.p2);
         din = din_v;
         @(posedge clk);
         #1;
         if (pressed !== din_v) pbad++;
         if (short_p === 1'b1) n_sh++;
         if (long_p === 1'b1) n_lg++;
         if (dbl_p === 1'b1) n_db++;
         if (first < 0 && (short_p === 1'b1 || long_p === 1'b1 || dbl_p === 1'b1)) first = c;
         if (int'(short_p === 1'b1) + int'(long_p === 1'b1) + int'(dbl_p === 1'b1) > 1) multi++;
      end
      check({tag, "_short"}, n_sh, s.n_short);
      check({tag, "_long"}, n_lg, s.n_long);
      check({tag, "_dbl"}, n_db, s.n_dbl);
      check({tag, "_first_edge"}, first, s.first);
      check({tag, "_overlap"}, multi, 0);
      check({tag, "_pressed_bad"}, pbad, 0);
   endtask

   scen_t vec [11];

   initial begin
      int n_sh;
      n_checks = 0;
      n_errors = 0;

      vec[0]  = '{3, 0, 0, 20, 1, 0, 0, 11};            // single click
      vec[1]  = '{3, 3, 3, 20, 0, 0, 1, 6};             // double click
      vec[2]  = '{30, 0, 0, 20, 0, LONG_HOLD30, 0, 16}; // long hold
      vec[3]  = '{16, 0, 0, 20, 1, 0, 0, 24};           // fall at PRESS1 terminal wins
      vec[4]  = '{15, 0, 0, 20, 1, 0, 0, 23};
      vec[5]  = '{17, 0, 0, 20, 0, 1, 0, 16};           // released just after long_p
      vec[6]  = '{3, 8, 2, 20, 0, 0, 1, 11};            // rise at WAIT2 terminal wins
      vec[7]  = '{3, 9, 2, 20, 2, 0, 0, 11};            // second press just too late
      vec[8]  = '{3, 7, 2, 20, 0, 0, 1, 10};
      vec[9]  = '{1, 0, 0, 20, 1, 0, 0, 9};             // shortest press
      vec[10] = '{3, 3, 30, 20, 0, 0, 1, 6};            // no long detection in PRESS2

      din   = 1'b0;
      n_rst = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_pressed", int'(pressed === 1'b1), 0);
      check("rst_short", int'(short_p === 1'b1), 0);
      check("rst_long", int'(long_p === 1'b1), 0);
      check("rst_dbl", int'(dbl_p === 1'b1), 0);
      check("rst_known", int'($isunknown({pressed, short_p, long_p, dbl_p})), 0);
      n_rst = 1'b1;
      @(posedge clk);
      #1;

      for (int i = 0; i < 11; i++) run_scen(vec[i], $sformatf("v%0d", i));

      // Button held through reset: release must not count as an event, next press must.
      n_rst = 1'b0;
      din   = 1'b1;
      #1;
      check("held_rst_outputs", out_sum(), 0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      run_scen('{5, 0, 0, 20, 0, 0, 0, -1}, "held_thru_rst");
      run_scen('{3, 0, 0, 20, 1, 0, 0, 11}, "after_held");

      // Reset in WAIT2 with cnt=5 discards the pending short_p.
      n_sh = 0;
      for (int c = 0; c < 9; c++) begin
         din = (c < 3);
         @(posedge clk);
         #1;
         if (short_p === 1'b1) n_sh++;
      end
      check("wait2_pre_rst_short", n_sh, 0);
      n_rst = 1'b0;
      #1;
      check("wait2_rst_outputs", out_sum(), 0);
      @(posedge clk);
      #1;
      n_rst = 1'b1;
      run_scen('{0, 0, 0, 20, 0, 0, 0, -1}, "wait2_after_rst");

      $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
      $finish;
   end

endmodule
